// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Transmit half of the UART link. Takes one word per valid/ready handshake
//   and shifts it out as start(0), data LSB first, even parity, stop(1).
//   Owns its own bit-period timer.
//
// Optional build macro: UART_TX_BREAK_EN (adds tx_break line-break control).
//
// Ports
//   clk              system clock, rising edge
//   n_rst            async reset, active low
//   tx_valid         host presents tx_data
//   tx_ready         block accepts tx_data this cycle
//   tx_data          word to send, bit 0 first
//   uart_data_width  data bits per frame (5..UART_DATA_WIDTH, else max)
//   tx               serial line, idles high, registered
//   tx_busy          frame in progress
//   tx_done          1-cycle pulse in the last cycle of the stop bit
//   tx_break         (UART_TX_BREAK_EN only) hold line low while in idle
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line high, ready for a word
// S_START  | start bit (0)
// S_DATA   | data bits, shift_reg[0] on the line
// S_PARITY | even parity bit
// S_STOP   | stop bit (1); tx_done in its last cycle
// S_BREAK  | line held low by tx_break (break build only)
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int UART_DATA_WIDTH = 8,
  parameter int UART_FRAME_SIZE = $clog2(UART_DATA_WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [UART_DATA_WIDTH-1:0] tx_data,
  input  logic [UART_FRAME_SIZE-1:0] uart_data_width,
  output logic                       tx,
  output logic                       tx_busy,
  output logic                       tx_done
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                       tx_break
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_FRAME_SIZE-1:0] W_MAX = UART_FRAME_SIZE'(UART_DATA_WIDTH);
  localparam logic [UART_FRAME_SIZE-1:0] W_MIN = UART_FRAME_SIZE'(5);
  localparam logic [UART_FRAME_SIZE-1:0] ONE   = UART_FRAME_SIZE'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                     state, state_nx;
  logic [CNT_W-1:0]           bit_cnt, bit_cnt_nx;
  logic [UART_FRAME_SIZE-1:0] data_idx, data_idx_nx;
  logic [UART_FRAME_SIZE-1:0] width_q, width_nx;
  logic [UART_DATA_WIDTH-1:0] shift_reg, shift_nx;
  logic                       parity_q, parity_nx;
  logic                       tx_q, tx_nx;

  logic                       brk;
  logic [UART_FRAME_SIZE-1:0] w_sel;
  logic                       par_sel;
  logic                       bit_end;

`ifdef UART_TX_BREAK_EN
  assign brk = tx_break;
`else
  assign brk = 1'b0;
`endif

  // Out-of-range widths fall back to the full word.
  assign w_sel   = (uart_data_width < W_MIN || uart_data_width > W_MAX) ? W_MAX : uart_data_width;
  assign bit_end = (bit_cnt == CNT_LAST);

  always_comb begin
    par_sel = 1'b0;
    for (int i = 0; i < UART_DATA_WIDTH; i++) begin
      if (i < int'(w_sel)) par_sel = par_sel ^ tx_data[i];
    end
  end

  // Break wins over a pending word, so ready drops as soon as break is seen.
  assign tx_ready = (state == S_IDLE) && !brk;
  assign tx_busy  = (state != S_IDLE) && (state != S_BREAK);
  assign tx_done  = (state == S_STOP) && bit_end;
  assign tx       = tx_q;

  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    data_idx_nx = data_idx;
    width_nx    = width_q;
    shift_nx    = shift_reg;
    parity_nx   = parity_q;
    tx_nx       = tx_q;
    unique case (state)
      S_IDLE: begin
        bit_cnt_nx = '0;
        if (brk) begin
          state_nx = S_BREAK;
          tx_nx    = 1'b0;
        end else if (tx_valid) begin
          state_nx    = S_START;
          data_idx_nx = '0;
          width_nx    = w_sel;
          shift_nx    = tx_data;
          parity_nx   = par_sel;
          tx_nx       = 1'b0;
        end
      end
      S_START: begin
        bit_cnt_nx = bit_cnt + 1'b1;
        if (bit_end) begin
          state_nx   = S_DATA;
          bit_cnt_nx = '0;
          tx_nx      = shift_reg[0];
        end
      end
      S_DATA: begin
        bit_cnt_nx = bit_cnt + 1'b1;
        if (bit_end) begin
          bit_cnt_nx = '0;
          if (data_idx == width_q - ONE) begin
            state_nx = S_PARITY;
            tx_nx    = parity_q;
          end else begin
            data_idx_nx = data_idx + ONE;
            shift_nx    = shift_reg >> 1;
            tx_nx       = shift_reg[1];
          end
        end
      end
      S_PARITY: begin
        bit_cnt_nx = bit_cnt + 1'b1;
        if (bit_end) begin
          state_nx   = S_STOP;
          bit_cnt_nx = '0;
          tx_nx      = 1'b1;
        end
      end
      S_STOP: begin
        bit_cnt_nx = bit_cnt + 1'b1;
        if (bit_end) begin
          state_nx   = S_IDLE;
          bit_cnt_nx = '0;
        end
      end
      S_BREAK: begin
        bit_cnt_nx = '0;
        if (!brk) begin
          state_nx = S_IDLE;
          tx_nx    = 1'b1;
        end
      end
      default: begin
        state_nx   = S_IDLE;
        bit_cnt_nx = '0;
        tx_nx      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      data_idx  <= '0;
      width_q   <= '0;
      shift_reg <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      data_idx  <= data_idx_nx;
      width_q   <= width_nx;
      shift_reg <= shift_nx;
      parity_q  <= parity_nx;
      tx_q      <= tx_nx;
    end
  end

endmodule
